x_stream_arbiter: RTL
=====================

X_STREAM_ARBITER -- requirements
Module: x_stream_arbiter

Interface
REQ-001 Parameter IDLE_X, default 2'b00: value driven on fsm_x while no transaction is in flight.
REQ-002 Parameter RESP_LAT, default 1, legal range 1..7: cycles from fsm_step to fsm_z sampling.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port req_valid  input  2  per-requester request valid; bit g belongs to requester g.
REQ-006 Port req_x0 / req_x1  input  2 each  X symbol offered by requester 0 / 1.
REQ-007 Port req_ready  output  2  one-hot acceptance strobe, at most one bit set.
REQ-008 Port fsm_x  output  2  X value driven to the shared 4-state sequence FSM.
REQ-009 Port fsm_step  output  1  one-cycle advance strobe to the FSM.
REQ-010 Port fsm_z  input  2  Z output of the shared FSM.
REQ-011 Port resp_valid  output  2  one-cycle response strobe to the granted requester.
REQ-012 Port resp_z  output  2  sampled fsm_z, valid while any resp_valid bit is set.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port txn_count  output  8  completed-transaction counter.

Function
REQ-015 Controller states: IDLE, DRIVE, WAIT, RESP; encoded in 2 bits.
REQ-016 IDLE: fsm_x = IDLE_X; if any req_valid, grant g per REQ-021, req_ready[g] = 1 in the same cycle (combinational), latch req_x<g> and g, next state DRIVE.
REQ-017 DRIVE: fsm_x = latched X, fsm_step = 1 for exactly this cycle, load wait counter with RESP_LAT-1, next state WAIT.
REQ-018 WAIT: fsm_x holds latched X, fsm_step = 0; counter decrements each cycle; on the cycle counter = 0, fsm_z is captured into resp_z, next state RESP.
REQ-019 RESP: resp_valid[g] = 1 for one cycle; txn_count increments; round-robin pointer updates; next state IDLE.
REQ-020 Latency: acceptance cycle N -> fsm_step at N+1 -> resp_valid at N+2+RESP_LAT; back-to-back acceptance no earlier than N+3+RESP_LAT.
REQ-021 Arbitration: single valid requester always granted; both valid -> requester equal to the pointer is granted; pointer becomes ~g after each RESP.
REQ-022 Requesters hold req_valid and req_x stable until req_ready; a deasserted req_valid in IDLE produces no grant.
REQ-023 req_valid changes outside IDLE are ignored; no request is queued.
REQ-024 txn_count wraps 8'hFF -> 8'h00 without any flag.
REQ-025 resp_z holds its last captured value outside RESP.

Reset
REQ-026 While reset = 0: state = IDLE, fsm_x = IDLE_X, fsm_step = 0, req_ready = 0, resp_valid = 0, resp_z = 2'b00, busy = 0, txn_count = 0, pointer = 0.
REQ-027 Reset asserted in DRIVE, WAIT or RESP drops the in-flight transaction with no resp_valid; after release, the first request is arbitrated from IDLE with pointer = 0.

Structure
REQ-028 Shared package holds the state encoding constants, the IDLE_X default, and the RESP_LAT bounds.
REQ-029 One sub-module, rr_grant2: two-requester round-robin grant (inputs valid[1:0], pointer; output one-hot grant).
REQ-030 The controller does not contain the sequence FSM; it drives that FSM only through fsm_x and fsm_step.

Verification
REQ-031 Bench stub FSM: fsm_z registers fsm_x on fsm_step.
REQ-032 Requester 0 only, req_x0 = 2'b11, RESP_LAT = 1 -> req_ready = 2'b01 at N, fsm_step at N+1, resp_valid = 2'b01 with resp_z = 2'b11 at N+3, txn_count = 1.
REQ-033 Both requesters valid from reset, x0 = 2'b10, x1 = 2'b01 -> grants in the order 0, 1, 0; resp_z in the order 10, 01, 10.
REQ-034 RESP_LAT = 4, single request -> fsm_x holds the value for 5 cycles, resp_valid at N+6, busy high from N+1 through N+6.
REQ-035 reset pulled low during WAIT -> no resp_valid, all outputs at reset values, next grant goes to requester 0.
REQ-036 256 consecutive transactions -> txn_count reads 8'h00 after the 256th RESP, no other side effect.

Source files
------------

// File: rtl/x_stream_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// x_stream_arbiter_pkg
// Shared definitions for the two-requester X-stream arbiter:
//   - ctrl_state_e       : controller state encoding (2 bits)
//   - IDLE_X_DEFAULT     : X symbol driven to the sequence FSM when nothing
//                          is in flight
//   - RESP_LAT_*         : legal bounds and default for the response latency
//   - wait_load()        : wait-counter reload value for a given latency
// ---------------------------------------------------------------------------
package x_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } ctrl_state_e;

  localparam logic [1:0] IDLE_X_DEFAULT   = 2'b00;
  localparam int         RESP_LAT_MIN     = 1;
  localparam int         RESP_LAT_MAX     = 7;
  localparam int         RESP_LAT_DEFAULT = 1;

  // The wait counter counts down to zero, so it is loaded with latency-1.
  // Out-of-range latencies are clamped so the counter width stays 3 bits.
  function automatic logic [2:0] wait_load(input int lat);
    int clamped;
    clamped = lat;
    if (clamped < RESP_LAT_MIN) clamped = RESP_LAT_MIN;
    if (clamped > RESP_LAT_MAX) clamped = RESP_LAT_MAX;
    return 3'(clamped - 1);
  endfunction

endpackage

// File: rtl/x_stream_arbiter_rr_grant2.sv
// ---------------------------------------------------------------------------
// rr_grant2
// Two-requester round-robin grant. A lone valid requester always wins; when
// both are valid the requester whose index equals the pointer wins.
// Ports:
//   valid   [1:0] in  : request valid per requester
//   pointer       in  : preferred requester when both are valid
//   grant   [1:0] out : one-hot grant (zero when nobody is valid)
// ---------------------------------------------------------------------------
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  output logic [1:0] grant
);

  // Single requester passes straight through; contention resolved by pointer.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = pointer ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/x_stream_arbiter.sv
// ---------------------------------------------------------------------------
// x_stream_arbiter
// Shares one external 4-state sequence FSM between two requesters. A granted
// requester's X symbol is driven to the FSM, the FSM is stepped once, and
// after RESP_LAT cycles its Z output is sampled and returned to the requester.
// Ports:
//   clk              in  : clock, all state updates on rising edge
//   reset            in  : asynchronous active-low reset
//   req_valid  [1:0] in  : request valid, bit g = requester g
//   req_x0     [1:0] in  : X symbol from requester 0
//   req_x1     [1:0] in  : X symbol from requester 1
//   req_ready  [1:0] out : one-hot acceptance strobe (combinational in IDLE)
//   fsm_x      [1:0] out : X value to the shared FSM
//   fsm_step         out : one-cycle advance strobe to the shared FSM
//   fsm_z      [1:0] in  : Z output of the shared FSM
//   resp_valid [1:0] out : one-cycle response strobe to the granted requester
//   resp_z     [1:0] out : captured fsm_z, held between responses
//   busy             out : high whenever a transaction is in flight
//   txn_count  [7:0] out : completed-transaction counter, wraps silently
// ---------------------------------------------------------------------------
module x_stream_arbiter
  import x_stream_arbiter_pkg::*;
#(
  parameter logic [1:0] IDLE_X   = IDLE_X_DEFAULT,
  parameter int         RESP_LAT = RESP_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_x0,
  input  logic [1:0] req_x1,
  output logic [1:0] req_ready,
  output logic [1:0] fsm_x,
  output logic       fsm_step,
  input  logic [1:0] fsm_z,
  output logic [1:0] resp_valid,
  output logic [1:0] resp_z,
  output logic       busy,
  output logic [7:0] txn_count
);

  localparam logic [2:0] WAIT_LOAD = wait_load(RESP_LAT);

  ctrl_state_e state;
  ctrl_state_e next_state;
  logic [1:0]  grant;
  logic [1:0]  latched_x;
  logic        granted;
  logic        pointer;
  logic [2:0]  wait_cnt;
  logic        take_request;

  rr_grant2 u_rr_grant2 (
    .valid   (req_valid),
    .pointer (pointer),
    .grant   (grant)
  );

  // A request is taken whenever the controller is idle and the arbiter has a
  // winner; the asynchronous reset overrides any update on the same edge.
  assign take_request = (state == ST_IDLE) && (grant != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. req_ready is combinational in IDLE, so it
  // is additionally gated by reset to stay quiet while reset is asserted.
  always_comb begin
    next_state = state;
    fsm_x      = IDLE_X;
    fsm_step   = 1'b0;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    busy       = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant != 2'b00) begin
          req_ready  = reset ? grant : 2'b00;
          next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        fsm_x      = latched_x;
        fsm_step   = 1'b1;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        fsm_x = latched_x;
        if (wait_cnt == 3'd0) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = granted ? 2'b10 : 2'b01;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Transaction datapath: latch the winner in IDLE, time the response in
  // WAIT, and account for the completed transaction in RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latched_x <= 2'b00;
      granted   <= 1'b0;
      pointer   <= 1'b0;
      wait_cnt  <= 3'd0;
      resp_z    <= 2'b00;
      txn_count <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_request) begin
            latched_x <= grant[1] ? req_x1 : req_x0;
            granted   <= grant[1];
          end
        end
        ST_DRIVE: begin
          wait_cnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt == 3'd0) begin
            resp_z <= fsm_z;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          txn_count <= txn_count + 8'd1;
          pointer   <= ~granted;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
